// File: rtl/vga_scan_generator.sv
// VGA raster scan generator: prescaled pixel/line counters, frame pulse, sync decode,
// and a delay line that re-aligns syncs/blanking with the colour returned by the screen mux.
module vga_scan_generator #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGB_in,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        active,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VISIBLE  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VISIBLE  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] divCnt;
    logic             pixEn;
    logic [10:0]      hCnt;
    logic [10:0]      vCnt;
    logic             hWrap;
    logic             vWrap;
    logic             hsRaw;
    logic             vsRaw;

    logic [PIPE_DELAY-1:0] hsDly;
    logic [PIPE_DELAY-1:0] vsDly;
    logic [PIPE_DELAY-1:0] actDly;
    logic [PIPE_DELAY-1:0] hsNext;
    logic [PIPE_DELAY-1:0] vsNext;
    logic [PIPE_DELAY-1:0] actNext;

    assign pixEn = (divCnt == DIV_LAST);
    assign hWrap = (hCnt == H_LAST);
    assign vWrap = (vCnt == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            divCnt <= '0;
        end else if (pixEn) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // Vertical counter only moves on the horizontal wrap, so both wrap together at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            hCnt         <= '0;
            vCnt         <= '0;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= pixEn && hWrap && vWrap;
            if (pixEn) begin
                if (hWrap) begin
                    hCnt <= '0;
                    vCnt <= vWrap ? 11'd0 : vCnt + 11'd1;
                end else begin
                    hCnt <= hCnt + 11'd1;
                end
            end
        end
    end

    assign pixelX = hCnt;
    assign pixelY = vCnt;
    assign active = (hCnt < H_VISIBLE) && (vCnt < V_VISIBLE);
    assign hsRaw  = !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
    assign vsRaw  = !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));

    // Stage 0 takes the live decode; later stages take the previous stage.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_delay
            if (gi == 0) begin : g_first
                assign hsNext[gi]  = hsRaw;
                assign vsNext[gi]  = vsRaw;
                assign actNext[gi] = active;
            end else begin : g_chain
                assign hsNext[gi]  = hsDly[gi-1];
                assign vsNext[gi]  = vsDly[gi-1];
                assign actNext[gi] = actDly[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            hsDly  <= '1;
            vsDly  <= '1;
            actDly <= '0;
        end else begin
            hsDly  <= hsNext;
            vsDly  <= vsNext;
            actDly <= actNext;
        end
    end

    // Output register captures RGB_in together with the matching delayed timing bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_hs      <= hsDly[PIPE_DELAY-1];
            vga_vs      <= vsDly[PIPE_DELAY-1];
            vga_blank_n <= actDly[PIPE_DELAY-1];
            if (actDly[PIPE_DELAY-1]) begin
                vga_r <= {RGB_in[7:5], RGB_in[7]};
                vga_g <= {RGB_in[4:2], RGB_in[4]};
                vga_b <= {RGB_in[1:0], RGB_in[1:0]};
            end else begin
                vga_r <= 4'h0;
                vga_g <= 4'h0;
                vga_b <= 4'h0;
            end
        end
    end

endmodule
